// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_mul_seq
// Description : Shift-and-add multiplier sequencer that borrows the shared
//               ALU (ADD/LSL/LSR) to form a*b mod 2^WIDTH.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mul_seq #(
    parameter int         WIDTH  = 8,
    parameter logic [4:0] OP_ADD = 5'b00100,
    parameter logic [4:0] OP_LSL = 5'b10000,
    parameter logic [4:0] OP_LSR = 5'b10001,
    parameter logic [4:0] OP_NOP = 5'b00000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic [4:0]       alu_op,
    input  logic [WIDTH-1:0] alu_out
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_ADD   = 3'd2,
        S_SHL   = 3'd3,
        S_SHR   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_zero = '0;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_product;

    // Datapath registers only load from alu_out in the state that owns them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_acc     <= c_zero;
            r_mcand   <= c_zero;
            r_mplier  <= c_zero;
            r_product <= c_zero;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand  <= a;
                        r_mplier <= b;
                        r_acc    <= c_zero;
                    end
                end
                S_CHECK: begin
                    if (r_mplier == c_zero) begin
                        r_product <= r_acc;
                    end
                end
                S_ADD:   r_acc    <= alu_out;
                S_SHL:   r_mcand  <= alu_out;
                S_SHR:   r_mplier <= alu_out;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        ready       = 1'b0;
        done        = 1'b0;
        alu_op      = OP_NOP;
        alu_in1     = c_zero;
        alu_in2     = c_zero;
        case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                // Multiplier drains to zero after at most WIDTH shifts.
                if (r_mplier == c_zero) begin
                    w_state_nxt = S_DONE;
                end else if (r_mplier[0]) begin
                    w_state_nxt = S_ADD;
                end else begin
                    w_state_nxt = S_SHL;
                end
            end
            S_ADD: begin
                alu_op      = OP_ADD;
                alu_in1     = r_acc;
                alu_in2     = r_mcand;
                w_state_nxt = S_SHL;
            end
            S_SHL: begin
                alu_op      = OP_LSL;
                alu_in1     = r_mcand;
                alu_in2     = c_one;
                w_state_nxt = S_SHR;
            end
            S_SHR: begin
                alu_op      = OP_LSR;
                alu_in1     = r_mplier;
                alu_in2     = c_one;
                w_state_nxt = S_CHECK;
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign product = r_product;

endmodule
`default_nettype wire

// File: tb/tb_alu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_mul_seq
// Description : Scoreboard bench for alu_mul_seq with a behavioural ALU and a
//               per-cycle expected trace derived from the multiply algorithm.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_mul_seq;

    localparam logic [4:0] c_add = 5'b00100;
    localparam logic [4:0] c_lsl = 5'b10000;
    localparam logic [4:0] c_lsr = 5'b10001;
    localparam logic [4:0] c_nop = 5'b00000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       ready;
    logic       done;
    logic [7:0] product;
    logic [7:0] alu_in1;
    logic [7:0] alu_in2;
    logic [4:0] alu_op;
    logic [7:0] alu_out;

    typedef struct packed {
        logic [4:0] op;
        logic [7:0] in1;
        logic [7:0] in2;
        logic       dn;
        logic       rdy;
        logic [7:0] prod;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] exp_hold = 8'h00;
    int         n_cmp = 0;
    int         n_bad = 0;

    alu_mul_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .done    (done),
        .product (product),
        .alu_in1 (alu_in1),
        .alu_in2 (alu_in2),
        .alu_op  (alu_op),
        .alu_out (alu_out)
    );

    always #5 clk = ~clk;

    // Shared ALU stand-in; NOP is the AND operation.
    always_comb begin
        alu_out = 8'h00;
        case (alu_op)
            c_add:   alu_out = alu_in1 + alu_in2;
            c_lsl:   alu_out = alu_in1 << alu_in2;
            c_lsr:   alu_out = alu_in1 >> alu_in2;
            c_nop:   alu_out = alu_in1 & alu_in2;
            default: alu_out = 8'h00;
        endcase
    end

    // Expected cycle-by-cycle behaviour of one accepted multiply.
    function automatic void push_txn(input logic [7:0] aa, input logic [7:0] bb);
        logic [7:0] acc = 8'h00;
        logic [7:0] mc  = aa;
        logic [7:0] mp  = bb;
        int         full = int'(aa) * int'(bb);
        logic [7:0] want = full[7:0];
        forever begin
            sb.push_back('{c_nop, 8'h00, 8'h00, 1'b0, 1'b0, exp_hold});
            if (mp == 8'h00) break;
            if (mp[0]) begin
                sb.push_back('{c_add, acc, mc, 1'b0, 1'b0, exp_hold});
                acc = acc + mc;
            end
            sb.push_back('{c_lsl, mc, 8'h01, 1'b0, 1'b0, exp_hold});
            mc = mc << 1;
            sb.push_back('{c_lsr, mp, 8'h01, 1'b0, 1'b0, exp_hold});
            mp = mp >> 1;
        end
        sb.push_back('{c_nop, 8'h00, 8'h00, 1'b1, 1'b0, want});
        exp_hold = want;
    endfunction

    task automatic drive_cycle(input logic s, input logic rst,
                               input logic [7:0] aa, input logic [7:0] bb);
        @(negedge clk);
        rst_n = !rst;
        start = s;
        a     = aa;
        b     = bb;
        if (rst) begin
            sb.delete();
            exp_hold = 8'h00;
        end else if (s && ready) begin
            push_txn(aa, bb);
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (!(sb.size() == 0 && ready) && k < 80) begin
            drive_cycle(1'b0, 1'b0, 8'($urandom), 8'($urandom));
            k++;
        end
        if (k >= 80) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: pending=%0d ready=%b, required pending=0 ready=1",
                     sb.size(), ready);
        end
    endtask

    function automatic logic [7:0] pick_b();
        case ($urandom_range(0, 4))
            0:       return 8'h00;
            1:       return 8'hFF;
            2:       return 8'h01 << $urandom_range(0, 7);
            default: return 8'($urandom);
        endcase
    endfunction

    // Monitor: one comparison per cycle, sampled just after the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) e = sb.pop_front();
            else               e = '{c_nop, 8'h00, 8'h00, 1'b0, 1'b1, exp_hold};
            n_cmp++;
            if (alu_op !== e.op || alu_in1 !== e.in1 || alu_in2 !== e.in2 ||
                done !== e.dn || ready !== e.rdy || product !== e.prod) begin
                n_bad++;
                $display("FAIL cycle@%0t: got op=%b in1=%0d in2=%0d done=%b ready=%b product=%0d; want op=%b in1=%0d in2=%0d done=%b ready=%b product=%0d",
                         $time, alu_op, alu_in1, alu_in2, done, ready, product,
                         e.op, e.in1, e.in2, e.dn, e.rdy, e.prod);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        drive_cycle(1'b0, 1'b1, 8'h00, 8'h00);
        drive_cycle(1'b0, 1'b1, 8'h00, 8'h00);
        drive_cycle(1'b0, 1'b0, 8'h00, 8'h00);

        drive_cycle(1'b1, 1'b0, 8'd3, 8'd5);
        wait_idle();
        drive_cycle(1'b1, 1'b0, 8'd7, 8'd0);
        wait_idle();
        drive_cycle(1'b1, 1'b0, 8'd16, 8'd16);
        wait_idle();
        drive_cycle(1'b1, 1'b0, 8'd255, 8'd255);
        wait_idle();

        // Start pulses while busy must be dropped.
        drive_cycle(1'b1, 1'b0, 8'd2, 8'd3);
        for (int i = 0; i < 7; i++) drive_cycle(1'b1, 1'b0, 8'd9, 8'd9);
        wait_idle();

        // Reset part-way through an operation, then a clean restart.
        drive_cycle(1'b1, 1'b0, 8'd5, 8'd7);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 8'd5, 8'd7);
        drive_cycle(1'b0, 1'b1, 8'd0, 8'd0);
        drive_cycle(1'b1, 1'b0, 8'd2, 8'd2);
        wait_idle();

        for (int i = 0; i < 1500; i++) begin
            drive_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 299) == 0,
                        8'($urandom), pick_b());
        end
        wait_idle();
        drive_cycle(1'b0, 1'b0, 8'h00, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
